// File: rtl/time_counter_pkg.sv
`default_nettype none
// time_counter_pkg: shared BCD types, hour constants and conversion helpers (rev 1.0).
package time_counter_pkg;

  typedef logic [3:0] bcd_t;

  localparam int HOUR_MAX_24 = 23;
  localparam int NOON        = 12;

  function automatic int bcd_to_int(input logic [15:0] v, input int digits);
    int acc;
    acc = 0;
    for (int i = 3; i >= 0; i--) begin
      if (i < digits) acc = acc * 10 + int'(v[4*i +: 4]);
    end
    return acc;
  endfunction

  function automatic logic [15:0] int_to_bcd(input int n);
    logic [15:0] r;
    int          v;
    r = '0;
    v = n;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_time_counter_if.sv
`default_nettype none
// bcd_time_counter_if: request/display bundle between a time-field counter and its user (rev 1.0).
interface bcd_time_counter_if #(
  parameter int DIGITS = 2
);
  logic                  tick;
  logic                  inc;
  logic                  dec;
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic                  twentyfour_mode;
  logic [4*DIGITS-1:0]   value;
  logic                  carry;
  logic                  am;
  logic                  pm;
  logic                  load_err;

  modport master (
    output tick, inc, dec, load, load_value, twentyfour_mode,
    input  value, carry, am, pm, load_err
  );

  modport slave (
    input  tick, inc, dec, load, load_value, twentyfour_mode,
    output value, carry, am, pm, load_err
  );
endinterface
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// bcd_digit: one BCD digit step (up or down) with per-digit wrap limit and carry/borrow out (rev 1.0).
module bcd_digit
  import time_counter_pkg::*;
#(
  parameter bcd_t LIMIT = 4'd9
) (
  input  wire bcd_t digit,
  input  wire logic up,
  input  wire logic down,
  output bcd_t      digit_next,
  output logic      carry_out,
  output logic      borrow_out
);

  always_comb begin
    digit_next = digit;
    carry_out  = 1'b0;
    borrow_out = 1'b0;
    if (up) begin
      if (digit >= LIMIT) begin
        digit_next = '0;
        carry_out  = 1'b1;
      end else begin
        digit_next = digit + 4'd1;
      end
    end else if (down) begin
      if (digit == 4'd0) begin
        digit_next = LIMIT;
        borrow_out = 1'b1;
      end else begin
        digit_next = digit - 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_time_counter.sv
`default_nettype none
// bcd_time_counter: BCD seconds/minutes/hours field with tick carry, manual set and 12/24 h display.
// Decrement is built only when TIME_COUNTER_DEC_EN is defined (rev 1.0).
module bcd_time_counter
  import time_counter_pkg::*;
#(
  parameter int DIGITS    = 2,
  parameter int MOD_MAX   = 59,
  parameter int HOUR_MODE = 0
) (
  input  wire logic         clk,
  input  wire logic         reset,
  bcd_time_counter_if.slave bus
);

  localparam int          W           = 4 * DIGITS;
  localparam int          MAX         = (HOUR_MODE != 0) ? HOUR_MAX_24 : MOD_MAX;
  localparam logic [15:0] MAX_BCD16   = int_to_bcd(MAX);
  localparam logic [W-1:0] MAX_BCD    = MAX_BCD16[W-1:0];

  logic [W-1:0] count, count_next, chain_val, wrapped_up, wrapped_dn;
  logic [W-1:0] disp, disp_next;
  logic [15:0]  load16;
  logic         manual_inc, manual_dec, step_up, step_dn;
  logic         digits_ok, load_ok, at_max, at_zero;
  logic         carry_q, carry_next, err_q, err_next;
  logic         am_q, pm_q, am_next, pm_next;

`ifdef TIME_COUNTER_DEC_EN
  assign manual_inc = bus.inc & ~bus.dec;
  assign manual_dec = bus.dec & ~bus.inc;
`else
  logic unused_dec;
  assign unused_dec = bus.dec;
  assign manual_inc = bus.inc;
  assign manual_dec = 1'b0;
`endif

  // A single digit chain serves both directions; only one action happens per cycle.
  assign step_dn = manual_dec;
  assign step_up = ~manual_dec;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic up_in, dn_in, cy_out, bw_out;
    bcd_t nd;
    if (i == 0) begin : g_lsd
      assign up_in = step_up;
      assign dn_in = step_dn;
    end else begin : g_upper
      assign up_in = g_digit[i-1].cy_out;
      assign dn_in = g_digit[i-1].bw_out;
    end
    bcd_digit #(.LIMIT(4'd9)) u_digit (
      .digit      (count[4*i +: 4]),
      .up         (up_in),
      .down       (dn_in),
      .digit_next (nd),
      .carry_out  (cy_out),
      .borrow_out (bw_out)
    );
    assign chain_val[4*i +: 4] = nd;
  end

  logic unused_msd;
  assign unused_msd = g_digit[DIGITS-1].cy_out | g_digit[DIGITS-1].bw_out;

  assign at_max     = (count == MAX_BCD);
  assign at_zero    = (count == '0);
  assign wrapped_up = at_max  ? '0      : chain_val;
  assign wrapped_dn = at_zero ? MAX_BCD : chain_val;

  always_comb begin
    load16         = '0;
    load16[W-1:0]  = bus.load_value;
    digits_ok      = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load16[4*i +: 4] > 4'd9) digits_ok = 1'b0;
    end
    load_ok = digits_ok && (bcd_to_int(load16, DIGITS) <= MAX);
  end

  always_comb begin
    count_next = count;
    carry_next = 1'b0;
    err_next   = 1'b0;
    if (bus.load) begin
      if (load_ok) count_next = bus.load_value;
      else         err_next   = 1'b1;
    end else if (manual_inc) begin
      count_next = wrapped_up;
    end else if (manual_dec) begin
      count_next = wrapped_dn;
    end else if (bus.tick) begin
      count_next = wrapped_up;
      carry_next = at_max;
    end
  end

  if (HOUR_MODE != 0) begin : g_hour
    int          hr, hr_shown;
    logic [15:0] disp16;
    always_comb begin
      hr       = bcd_to_int(16'(count_next), 2);
      hr_shown = hr;
      am_next  = 1'b0;
      pm_next  = 1'b0;
      if (!bus.twentyfour_mode) begin
        if (hr == 0) begin
          hr_shown = NOON;
          am_next  = 1'b1;
        end else if (hr < NOON) begin
          am_next  = 1'b1;
        end else if (hr == NOON) begin
          pm_next  = 1'b1;
        end else begin
          hr_shown = hr - NOON;
          pm_next  = 1'b1;
        end
      end
      disp16    = int_to_bcd(hr_shown);
      disp_next = disp16[W-1:0];
    end
  end else begin : g_plain
    logic unused_mode;
    assign unused_mode = bus.twentyfour_mode;
    assign disp_next   = count_next;
    assign am_next     = 1'b0;
    assign pm_next     = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      disp    <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      am_q    <= 1'b0;
      pm_q    <= 1'b0;
    end else begin
      count   <= count_next;
      disp    <= disp_next;
      carry_q <= carry_next;
      err_q   <= err_next;
      am_q    <= am_next;
      pm_q    <= pm_next;
    end
  end

  assign bus.value    = disp;
  assign bus.carry    = carry_q;
  assign bus.load_err = err_q;
  assign bus.am       = am_q;
  assign bus.pm       = pm_q;

endmodule
`default_nettype wire

// File: doc/bcd_time_counter.md
# bcd_time_counter

Parametrised, synchronous BCD time-field counter for the clock datapath: one instance each for seconds, minutes and hours. Replaces the unclocked hours counter. It counts on a one-cycle tick from the stage below and emits a registered carry to the stage above. It also supports manual set (increment, load, optional decrement), and in hour mode presents 12/24-hour display with AM/PM flags.

## Interface
- DIGITS, 2: number of BCD digits; value width is 4*DIGITS; legal 1..4.
- MOD_MAX, 59: largest count before wrap to 0, as an integer; must be < 10^DIGITS; ignored when HOUR_MODE=1.
- HOUR_MODE, 0: 1 = hours field with internal range 0..23, 12/24 display and am/pm; requires DIGITS=2.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- tick  in  1  automatic increment request; one-cycle pulse, normally the lower stage's carry.
- inc  in  1  manual increment, one-cycle pulse (already debounced/edge-detected upstream).
- dec  in  1  manual decrement pulse; active only with TIME_COUNTER_DEC_EN.
- load  in  1  synchronous load strobe.
- load_value  in  4*DIGITS  BCD value to load; hours are always given in 24-hour form, 00..23.
- twentyfour_mode  in  1  hour display mode; 1 = 24 h, 0 = 12 h; ignored unless HOUR_MODE=1.
- value  out  4*DIGITS  registered BCD display value.
- carry  out  1  registered one-cycle pulse on tick-driven wrap.
- am, pm  out  1 each  registered; meaningful only for HOUR_MODE=1 in 12 h mode, else both 0.
- load_err  out  1  registered one-cycle pulse when a load is rejected.

## Operation
- Internal state is a canonical BCD count 0..MAX, where MAX=23 in hour mode and MAX=MOD_MAX otherwise. Display is derived from this state, so changing mode never alters the count.
- Per-edge priority, one action per cycle:
  - load first;
  - then manual (inc xor dec);
  - then tick.
  - A tick in a cycle with load or manual action is dropped.
  - inc and dec together count as no manual action, so a tick in that cycle is honoured.
- Load: accepted only if every digit is at most 9 and the value is at most MAX; the state takes load_value.
  - Otherwise the state is unchanged and load_err pulses.
  - carry is never asserted by a load.
- Increment: at MAX the count goes to 0, else it goes to count+1, using BCD carry between digits.
  - carry pulses only when the wrap was caused by tick. A manual wrap gives no carry.
- Decrement (macro only): at 0 the count goes to MAX, else count−1. Decrement never produces carry.
- Hour display when twentyfour_mode=1: value is the count; am=pm=0.
- Hour display when twentyfour_mode=0:
  - count 00 shows 12 with am=1;
  - counts 01..11 show the count with am=1;
  - count 12 shows 12 with pm=1;
  - counts 13..23 show count−12 with pm=1.
  - The 11 PM → 12 AM step is the 23→00 wrap, which is also the day carry.
- Non-hour mode: value is the count; am=pm=0.

## Timing
- Reset (asynchronous assert, synchronous release to clk):
  - count = 0;
  - carry = 0 and load_err = 0;
  - in hour mode, value = 0x12 with am=1, pm=0 if twentyfour_mode=0 at the first clock after release, else value = 0x00 with am=pm=0. Before that clock, value=0, am=0, pm=0.
- Latency: a request sampled at edge N is visible on value, carry, am, pm and load_err immediately after edge N. value and am/pm are registered from the next-state decode.
- carry and load_err are high for exactly one cycle per event and cannot merge. Back-to-back wraps produce back-to-back single pulses.
- A twentyfour_mode change affects value/am/pm from the next edge; carry is unaffected.
- Reset asserted mid-cycle overrides every request in flight. Pulses pending at reset are lost.

## Configuration
- TIME_COUNTER_DEC_EN defined: dec is functional as described above.
- TIME_COUNTER_DEC_EN undefined: dec is ignored and the decrement logic is not built. The port list is identical in both cases.

## Structure
- Package time_counter_pkg holds:
  - the 4-bit BCD digit typedef;
  - HOUR_MAX_24 = 23 and NOON = 12;
  - a BCD-to-integer function used for load validation.
- Sub-module bcd_digit implements one digit: inc/dec, per-digit wrap limit, carry/borrow out. It is instantiated DIGITS times, and the top applies the whole-value MAX wrap.

## Test plan
- Minutes config (DIGITS=2, MOD_MAX=59): at count 59, tick → value 00 and carry high for exactly 1 cycle.
- Hour mode, 12 h: tick 24 times from reset → sequence 12AM, 1AM..11AM, 12PM, 1PM..11PM, then 12AM with one carry on the last tick.
- Hour mode: load 0x17 with twentyfour_mode=0 → value 05, pm=1. Toggle to 24 h → value 17, am=pm=0 on the next edge.
- load 0x24 in hour mode, or 0x5A in minutes config → state unchanged, load_err pulses 1 cycle.
- At count 59, inc and tick in the same cycle → value 00, carry stays 0, the tick is dropped. Then inc and dec together with tick at count 07 → value 08.
- With TIME_COUNTER_DEC_EN: dec at 00 → 59 with no carry. Without it: dec at 00 → value stays 00. Asserting reset mid-count returns value to 00 asynchronously.
